// File: rtl/sseg2bcd_capture_if.sv
// Seven-segment sampling bus: multiplexed display inputs and recovered BCD outputs.
interface sseg2bcd_capture_if;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic [3:0]  digit_valid;
  logic [3:0]  err;
  logic        upd;

  modport master (
    output sseg,
    output an,
    input  bcd,
    input  digit_valid,
    input  err,
    input  upd
  );

  modport slave (
    input  sseg,
    input  an,
    output bcd,
    output digit_valid,
    output err,
    output upd
  );
endinterface

// File: rtl/sseg2bcd_capture.sv
// Recovers BCD digits from a multiplexed, active-low seven-segment display bus.
// A digit is captured once per stable interval; a per-digit timeout marks stale digits.
module sseg2bcd_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  sseg2bcd_capture_if.slave bus
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALE_W = 16;
  localparam int unsigned SAMP_W  = 11;
  localparam int unsigned NDIG    = 4;

  localparam logic [CNT_W-1:0]   STAB_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT);

  logic [SAMP_W-1:0]  prev_q;
  logic [SAMP_W-1:0]  samp;
  logic [CNT_W-1:0]   stab_q;
  logic [CNT_W-1:0]   stab_d;
  logic [STALE_W-1:0] stale_q [NDIG];
  logic [STALE_W-1:0] stale_d [NDIG];
  logic [15:0]        bcd_q;
  logic [15:0]        bcd_d;
  logic [3:0]         valid_q;
  logic [3:0]         valid_d;
  logic [3:0]         err_q;
  logic [3:0]         err_d;
  logic               chg_q;
  logic               chg_d;
  logic               upd_q;

  logic               reach;
  logic               sel_ok;
  logic [1:0]         sel;
  logic [3:0]         cap_nib;
  logic               cap_valid;
  logic               cap_err;
  logic               capture;

  // Stability tracking: count 0 means no previous sample, so the first edge after reset starts at 1.
  always_comb begin
    samp = {bus.an, bus.sseg};
    if ((stab_q == '0) || (samp != prev_q)) begin
      stab_d = CNT_W'(1);
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + CNT_W'(1);
    end
    reach = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);
  end

  // Exactly one active-low anode selects a digit; anything else suppresses capture.
  always_comb begin
    sel_ok = 1'b1;
    sel    = 2'd0;
    case (bus.an)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_ok = 1'b0;
    endcase
    capture = reach && sel_ok;
  end

  // Segment pattern decode (a..g, active-low).
  always_comb begin
    cap_nib   = 4'hF;
    cap_valid = 1'b1;
    cap_err   = 1'b0;
    case (bus.sseg)
      7'b0000001: cap_nib = 4'd0;
      7'b1001111: cap_nib = 4'd1;
      7'b0010010: cap_nib = 4'd2;
      7'b0000110: cap_nib = 4'd3;
      7'b1001100: cap_nib = 4'd4;
      7'b0100100: cap_nib = 4'd5;
      7'b0100000: cap_nib = 4'd6;
      7'b0001111: cap_nib = 4'd7;
      7'b0000000: cap_nib = 4'd8;
      7'b0000100: cap_nib = 4'd9;
      7'b1111111: cap_valid = 1'b0;
      default: begin
        cap_valid = 1'b0;
        cap_err   = 1'b1;
      end
    endcase
  end

  // Per-digit update: a capture beats a coincident timeout and reloads the stale counter.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = err_q;
    chg_d   = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      stale_d[i] = stale_q[i];
      if (capture && (sel == 2'(i))) begin
        stale_d[i]      = '0;
        bcd_d[4*i +: 4] = cap_nib;
        valid_d[i]      = cap_valid;
        err_d[i]        = cap_err;
        chg_d           = (bcd_q[4*i +: 4] != cap_nib) ||
                          (valid_q[i] != cap_valid) ||
                          (err_q[i] != cap_err);
      end else begin
        if (stale_q[i] != STALE_MAX) begin
          stale_d[i] = stale_q[i] + STALE_W'(1);
        end
        if (stale_q[i] == (STALE_MAX - STALE_W'(1))) begin
          valid_d[i]      = 1'b0;
          bcd_d[4*i +: 4] = 4'hF;
        end
      end
    end
  end

  // State register; upd trails the capturing edge by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      stab_q  <= '0;
      for (int i = 0; i < int'(NDIG); i++) begin
        stale_q[i] <= '0;
      end
      bcd_q   <= 16'hFFFF;
      valid_q <= 4'b0000;
      err_q   <= 4'b0000;
      chg_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      prev_q  <= samp;
      stab_q  <= stab_d;
      for (int i = 0; i < int'(NDIG); i++) begin
        stale_q[i] <= stale_d[i];
      end
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      chg_q   <= chg_d;
      upd_q   <= chg_q;
    end
  end

  assign bus.bcd         = bcd_q;
  assign bus.digit_valid = valid_q;
  assign bus.err         = err_q;
  assign bus.upd         = upd_q;

endmodule

// File: tb/tb_sseg2bcd_capture.sv
// Directed bench: two instances share stimulus; dut_b uses a short timeout for staleness checks.
module tb_sseg2bcd_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   pa;
  int   pb;
  int   acc_a;

  always #5 clk = ~clk;

  sseg2bcd_capture_if bus_a ();
  sseg2bcd_capture_if bus_b ();

  sseg2bcd_capture #(.STABLE_CYCLES(4), .TIMEOUT(1024)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  sseg2bcd_capture #(.STABLE_CYCLES(4), .TIMEOUT(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] an, input logic [6:0] sseg);
    bus_a.an   = an;
    bus_a.sseg = sseg;
    bus_b.an   = an;
    bus_b.sseg = sseg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus_a.upd === 1'b1) na++;
      if (bus_b.upd === 1'b1) nb++;
    end
  endtask

  initial begin
    set_in(4'b1111, 7'b1111111);
    #12;
    chk("rst_bcd",   32'(bus_a.bcd), 32'hFFFF);
    chk("rst_valid", 32'(bus_a.digit_valid), 32'h0);
    chk("rst_err",   32'(bus_a.err), 32'h0);
    chk("rst_upd",   32'(bus_a.upd), 32'h0);
    chk("rst_bcd_b", 32'(bus_b.bcd), 32'hFFFF);
    rst_n = 1'b1;
    tick();

    // Digit 0 = 3 after the fourth stable edge, upd one cycle later
    set_in(4'b1110, 7'b0000110);
    repeat (3) tick();
    chk("pre_cap_valid", 32'(bus_a.digit_valid), 32'h0);
    tick();
    chk("cap3_bcd",   32'(bus_a.bcd), 32'hFFF3);
    chk("cap3_valid", 32'(bus_a.digit_valid), 32'h1);
    chk("cap3_err",   32'(bus_a.err), 32'h0);
    chk("cap3_upd_early", 32'(bus_a.upd), 32'h0);
    tick();
    chk("cap3_upd", 32'(bus_a.upd), 32'h1);
    tick();
    chk("cap3_upd_drop", 32'(bus_a.upd), 32'h0);

    // Long hold: no recapture
    hold(20, pa, pb);
    chk("hold_upd_cnt", 32'(pa), 32'h0);
    chk("hold_bcd",     32'(bus_a.bcd), 32'hFFF3);

    set_in(4'b1110, 7'b0100000);
    repeat (4) tick();
    chk("cap6_bcd", 32'(bus_a.bcd), 32'hFFF6);
    tick();
    chk("cap6_upd", 32'(bus_a.upd), 32'h1);
    tick();
    chk("cap6_upd_drop", 32'(bus_a.upd), 32'h0);

    // Recapturing an identical value must not pulse upd
    set_in(4'b1111, 7'b0100000);
    tick();
    set_in(4'b1110, 7'b0100000);
    hold(5, pa, pb);
    chk("same_bcd",     32'(bus_a.bcd), 32'hFFF6);
    chk("same_upd_cnt", 32'(pa), 32'h0);

    // Digit 2: value 7, then blank, then undecodable
    set_in(4'b1011, 7'b0001111);
    repeat (4) tick();
    chk("cap7_bcd",   32'(bus_a.bcd), 32'hF7F6);
    chk("cap7_valid", 32'(bus_a.digit_valid), 32'h5);
    tick();
    chk("cap7_upd", 32'(bus_a.upd), 32'h1);

    set_in(4'b1011, 7'b1111111);
    repeat (4) tick();
    chk("blank_bcd",   32'(bus_a.bcd), 32'hFFF6);
    chk("blank_valid", 32'(bus_a.digit_valid), 32'h1);
    chk("blank_err",   32'(bus_a.err), 32'h0);
    tick();
    chk("blank_upd", 32'(bus_a.upd), 32'h1);

    set_in(4'b1011, 7'b0110000);
    repeat (4) tick();
    chk("bad_bcd",   32'(bus_a.bcd), 32'hFFF6);
    chk("bad_valid", 32'(bus_a.digit_valid), 32'h1);
    chk("bad_err",   32'(bus_a.err), 32'h4);
    tick();
    chk("bad_upd", 32'(bus_a.upd), 32'h1);

    // Two anodes low, then anodes toggling every two cycles: nothing captured
    set_in(4'b1100, 7'b0000000);
    hold(10, pa, pb);
    acc_a = pa;
    for (int k = 0; k < 6; k++) begin
      set_in((k % 2 == 1) ? 4'b1101 : 4'b1110, 7'b0000000);
      hold(2, pa, pb);
      acc_a += pa;
    end
    chk("multi_upd_cnt", 32'(acc_a), 32'h0);
    chk("multi_bcd",     32'(bus_a.bcd), 32'hFFF6);
    chk("multi_valid",   32'(bus_a.digit_valid), 32'h1);
    chk("multi_err",     32'(bus_a.err), 32'h4);

    // Timeout on dut_b: digit 1 = 9, then display blanked
    set_in(4'b1101, 7'b0000100);
    repeat (4) tick();
    chk("to_cap_nib",   32'(bus_b.bcd[7:4]), 32'h9);
    chk("to_cap_valid", 32'(bus_b.digit_valid[1]), 32'h1);
    set_in(4'b1111, 7'b1111111);
    tick();
    chk("to_cap_upd", 32'(bus_b.upd), 32'h1);
    hold(14, pa, pb);
    chk("to_pre_upd_cnt", 32'(pb), 32'h0);
    chk("to_pre_valid",   32'(bus_b.digit_valid[1]), 32'h1);
    tick();
    chk("to_valid", 32'(bus_b.digit_valid[1]), 32'h0);
    chk("to_nib",   32'(bus_b.bcd[7:4]), 32'hF);
    chk("to_err",   32'(bus_b.err[1]), 32'h0);
    chk("to_upd",   32'(bus_b.upd), 32'h0);
    hold(4, pa, pb);
    chk("to_post_upd_cnt", 32'(pb), 32'h0);
    chk("long_to_bcd_a",   32'(bus_a.bcd), 32'hFF96);

    // Short asynchronous reset pulse mid-count
    set_in(4'b0111, 7'b0000001);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd",   32'(bus_a.bcd), 32'hFFFF);
    chk("arst_valid", 32'(bus_a.digit_valid), 32'h0);
    chk("arst_err",   32'(bus_a.err), 32'h0);
    chk("arst_upd",   32'(bus_a.upd), 32'h0);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_no_carry", 32'(bus_a.digit_valid), 32'h0);
    tick();
    chk("arst_cap_bcd",   32'(bus_a.bcd), 32'h0FFF);
    chk("arst_cap_valid", 32'(bus_a.digit_valid), 32'h8);
    tick();
    chk("arst_cap_upd", 32'(bus_a.upd), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
